// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_pkg;

  localparam int unsigned PWM_PERIOD_DEFAULT = 2_000_000;
  localparam int unsigned NUM_REQ            = 4;
  localparam int unsigned DUTY_W             = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_HOLD      = 2'd2
  } sched_state_e;

  // First requester at or after ptr, wrapping 3->0; returns ptr when nothing is pending.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] sel;
    sel = ptr;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) sel = idx;
    end
    return sel;
  endfunction

  // Extracts requester idx's duty code from the packed duty bus.
  function automatic logic [1:0] duty_code(input logic [7:0] req_duty, input logic [1:0] idx);
    return req_duty[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/pwm_duty_sched_if.sv
// Requester / PWM-side signal bundle of the duty scheduler.
// Latency: n/a (wires only).
// Backpressure: req is held by the requester until its ack pulse.
interface pwm_duty_sched_if;
  import pwm_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DUTY_W-1:0] req_duty;
  logic [NUM_REQ-1:0]        ack;
  logic [DUTY_W-1:0]         duty_o;
  logic [1:0]                grant_id;
  logic                      busy;
  logic                      period_tick;

  modport master (
    output req, req_duty,
    input  ack, duty_o, grant_id, busy, period_tick
  );

  modport slave (
    input  req, req_duty,
    output ack, duty_o, grant_id, busy, period_tick
  );

endinterface

// File: rtl/pwm_period_timer.sv
// Free-running period counter 0..PERIOD-1 with a one-cycle tick on the last count.
// Latency: tick is registered and coincides with the counter holding PERIOD-1.
// Backpressure: none; runs every cycle outside reset.
module pwm_period_timer
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD = PWM_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned  CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count wraps after LAST; tick is precomputed so it lines up with cnt_q == LAST.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_d == LAST);
  end

  // Counter and tick registers, cleared by reset so the PWM generator stays aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pwm_duty_sched.sv
// Round-robin duty scheduler: grants one requester, applies its duty on a period boundary, holds it.
// Latency: grant 1 cycle after req; duty/ack 1 cycle after the next period_tick following the grant.
// Backpressure: requests wait while busy; a requester dropping req before application is abandoned.
module pwm_duty_sched
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD       = PWM_PERIOD_DEFAULT,
  parameter int unsigned HOLD_PERIODS = 4
) (
  input logic             clk,
  input logic             rst,
  pwm_duty_sched_if.slave bus
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_PERIODS - 1);

  sched_state_e       state_q, state_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic [1:0]         duty_lat_q, duty_lat_d;
  logic [1:0]         duty_q, duty_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               busy_q, busy_d;

  logic               tick;
  logic [1:0]         pick;

  pwm_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign pick = rr_pick(bus.req, rr_ptr_q);

  // Next-state logic: grant in IDLE, apply on the period boundary, hold for HOLD_PERIODS ticks.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    duty_lat_d = duty_lat_q;
    duty_d     = duty_q;
    ack_d      = '0;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        // The grant only latches here; application waits for a tick seen in WAIT_EDGE.
        if (|bus.req) begin
          grant_id_d = pick;
          duty_lat_d = duty_code(bus.req_duty, pick);
          state_d    = ST_WAIT_EDGE;
        end
      end
      ST_WAIT_EDGE: begin
        // Withdrawal takes priority over a coincident tick; rr_ptr stays put.
        if (!bus.req[grant_id_q]) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          duty_d     = duty_lat_q;
          ack_d      = 4'b0001 << grant_id_q;
          hold_cnt_d = HOLD_LOAD;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (hold_cnt_q == 8'd0) begin
            rr_ptr_d = grant_id_q + 2'd1;
            state_d  = ST_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Scheduler registers; reset abandons any grant in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_id_q <= 2'd0;
      duty_lat_q <= 2'd0;
      duty_q     <= 2'd0;
      ack_q      <= '0;
      hold_cnt_q <= 8'd0;
      rr_ptr_q   <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      duty_lat_q <= duty_lat_d;
      duty_q     <= duty_d;
      ack_q      <= ack_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.duty_o      = duty_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.period_tick = tick;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Bench for pwm_duty_sched: directed table, boundary and fairness sequences, random vs. reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_duty_sched;

  localparam int P  = 10;
  localparam int H0 = 2;
  localparam int H1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pwm_duty_sched_if b0();
  pwm_duty_sched_if b1();

  pwm_duty_sched #(.PERIOD(P), .HOLD_PERIODS(H0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  pwm_duty_sched #(.PERIOD(P), .HOLD_PERIODS(H1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    bit         rst;
    logic [3:0] req;
    logic [7:0] rd;
    logic       busy;
    logic [1:0] gid;
    logic [1:0] duty;
    logic [3:0] ack;
  } vec_t;

  typedef struct {
    bit         have;
    int         gid;
    logic [1:0] gduty;
    int         apply_c;
    int         rel_c;
    int         rr;
    logic [1:0] duty;
    logic [3:0] ack;
  } mdl_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, bit r, logic [3:0] q, logic [7:0] d,
                              logic b, logic [1:0] g, logic [1:0] du, logic [3:0] a);
    vec_t v;
    v.n = n; v.rst = r; v.req = q; v.rd = d;
    v.busy = b; v.gid = g; v.duty = du; v.ack = a;
    return v;
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic chk_out0(input string tag, input int c, input logic b, input logic [1:0] g,
                          input logic [1:0] d, input logic [3:0] a, input logic t);
    chk({tag, "_busy"}, c, 32'(b0.busy), 32'(b));
    chk({tag, "_gid"},  c, 32'(b0.grant_id), 32'(g));
    chk({tag, "_duty"}, c, 32'(b0.duty_o), 32'(d));
    chk({tag, "_ack"},  c, 32'(b0.ack), 32'(a));
    chk({tag, "_tick"}, c, 32'(b0.period_tick), 32'(t));
  endtask

  task automatic chk_out1(input string tag, input int c, input logic b, input logic [1:0] g,
                          input logic [1:0] d, input logic [3:0] a, input logic t);
    chk({tag, "_busy"}, c, 32'(b1.busy), 32'(b));
    chk({tag, "_gid"},  c, 32'(b1.grant_id), 32'(g));
    chk({tag, "_duty"}, c, 32'(b1.duty_o), 32'(d));
    chk({tag, "_ack"},  c, 32'(b1.ack), 32'(a));
    chk({tag, "_tick"}, c, 32'(b1.period_tick), 32'(t));
  endtask

  // Holds reset over two edges, checks the cleared state while rst is high, releases into cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    b0.req = '0; b0.req_duty = '0;
    b1.req = '0; b1.req_duty = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_out0("rst0", -1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    chk_out1("rst1", -1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference: schedule in absolute cycles; grant at c applies at the first tick cycle after c,
  // releases h periods later. Updates the outputs expected in cycle c+1.
  task automatic model_step(inout mdl_t m, input int h, input int c,
                            input logic [3:0] rq, input logic [7:0] rd);
    int  pick;
    bit  found;
    m.ack = 4'd0;
    if (!m.have) begin
      if (rq != 4'd0) begin
        found = 1'b0;
        pick  = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && rq[(m.rr + k) % 4]) begin
            pick  = (m.rr + k) % 4;
            found = 1'b1;
          end
        end
        m.have    = 1'b1;
        m.gid     = pick;
        m.gduty   = rd[2*pick +: 2];
        m.apply_c = (c + 1) + (P - 1 - ((c + 1) % P));
        m.rel_c   = m.apply_c + h * P;
      end
    end else if (c <= m.apply_c) begin
      if (!rq[m.gid]) begin
        m.have = 1'b0;
      end else if (c == m.apply_c) begin
        m.duty = m.gduty;
        m.ack  = 4'(1 << m.gid);
      end
    end else if (c == m.rel_c) begin
      m.have = 1'b0;
      m.rr   = (m.gid + 1) % 4;
    end
  endtask

  // Directed per-cycle table on instance 0 (HOLD_PERIODS=2).
  task automatic run_table();
    int tc = 0;
    int c  = 0;
    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].n; r++) begin
        rst         = tbl[k].rst;
        b0.req      = tbl[k].req;
        b0.req_duty = tbl[k].rd;
        @(negedge clk);
        chk_out0("tbl", c, tbl[k].busy, tbl[k].gid, tbl[k].duty, tbl[k].ack, 1'(tc == P - 1));
        tc = tbl[k].rst ? 0 : (tc + 1) % P;
        c++;
        @(posedge clk); #1;
      end
    end
    rst = 1'b0;
  endtask

  // Instance 1 (HOLD_PERIODS=1): request raised exactly in the tick cycle 9.
  task automatic run_boundary();
    logic       eb;
    logic [1:0] ed;
    logic [3:0] ea;
    for (int c = 0; c < 34; c++) begin
      b1.req      = (c >= 9 && c <= 20) ? 4'b0001 : 4'b0000;
      b1.req_duty = 8'h03;
      @(negedge clk);
      eb = (c >= 10 && c <= 29);
      ed = (c >= 20) ? 2'd3 : 2'd0;
      ea = (c == 20) ? 4'b0001 : 4'b0000;
      chk_out1("bnd", c, eb, 2'd0, ed, ea, 1'((c % P) == P - 1));
      @(posedge clk); #1;
    end
  endtask

  // All four requesters held: acks must rotate 0,1,2,3,0 with matching duty.
  task automatic run_fairness();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int got = 0;
    int idx;
    b0.req_duty = 8'hE4;
    b0.req      = 4'hF;
    for (int c = 0; c < 400 && got < 5; c++) begin
      @(negedge clk);
      if (b0.ack != 4'd0) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (b0.ack[i]) idx = i;
        chk("fair_onehot", c, 32'($onehot(b0.ack)), 32'd1);
        chk("fair_order", c, 32'(idx), 32'(exp_order[got]));
        chk("fair_duty", c, 32'(b0.duty_o), 32'(idx));
        got++;
      end
      @(posedge clk); #1;
    end
    if (got < 5) chk("fair_timeout", got, 32'(got), 32'd5);
    b0.req = 4'h0;
  endtask

  // Random requesters on both instances against the reference model.
  task automatic run_random(input int ncyc);
    mdl_t       m[2];
    bit         act[2][4];
    logic [1:0] gd[2][4];
    logic [3:0] seen[2];
    logic [3:0] rq[2];
    logic [7:0] rdv[2];
    logic       t;
    for (int j = 0; j < 2; j++) begin
      m[j].have = 1'b0; m[j].gid = 0; m[j].gduty = 2'd0; m[j].apply_c = 0;
      m[j].rel_c = 0; m[j].rr = 0; m[j].duty = 2'd0; m[j].ack = 4'd0;
      seen[j] = 4'd0;
      for (int i = 0; i < 4; i++) begin act[j][i] = 1'b0; gd[j][i] = 2'd0; end
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int j = 0; j < 2; j++) begin
        rq[j] = 4'd0; rdv[j] = 8'd0;
        for (int i = 0; i < 4; i++) begin
          if (act[j][i]) begin
            if (seen[j][i] || ($urandom % 40) == 0) act[j][i] = 1'b0;
          end else if (($urandom % 6) == 0) begin
            act[j][i] = 1'b1;
            gd[j][i]  = 2'($urandom_range(0, 3));
          end
          rq[j][i]        = act[j][i];
          rdv[j][2*i +: 2] = gd[j][i];
        end
      end
      b0.req = rq[0]; b0.req_duty = rdv[0];
      b1.req = rq[1]; b1.req_duty = rdv[1];
      @(negedge clk);
      t = 1'((c % P) == P - 1);
      chk_out0("rnd0", c, m[0].have, 2'(m[0].gid), m[0].duty, m[0].ack, t);
      chk_out1("rnd1", c, m[1].have, 2'(m[1].gid), m[1].duty, m[1].ack, t);
      seen[0] = b0.ack;
      seen[1] = b1.ack;
      model_step(m[0], H0, c, rq[0], rdv[0]);
      model_step(m[1], H1, c, rq[1], rdv[1]);
      @(posedge clk); #1;
    end
    b0.req = '0;
    b1.req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // cycle count, rst, req, req_duty, busy, grant_id, duty_o, ack
    tbl.push_back(mk( 2, 0, 4'b0000, 8'h00, 0, 0, 0, 4'b0000)); // c0-1 idle
    tbl.push_back(mk( 1, 0, 4'b0001, 8'h02, 0, 0, 0, 4'b0000)); // c2 req0 raised
    tbl.push_back(mk( 7, 0, 4'b0001, 8'h02, 1, 0, 0, 4'b0000)); // c3-9 waiting for tick
    tbl.push_back(mk( 1, 0, 4'b0001, 8'h02, 1, 0, 2, 4'b0001)); // c10 applied
    tbl.push_back(mk(19, 0, 4'b0000, 8'h00, 1, 0, 2, 4'b0000)); // c11-29 hold
    tbl.push_back(mk( 3, 0, 4'b0000, 8'h00, 0, 0, 2, 4'b0000)); // c30-32 released
    tbl.push_back(mk( 1, 0, 4'b0010, 8'h04, 0, 0, 2, 4'b0000)); // c33 req1
    tbl.push_back(mk( 1, 0, 4'b0010, 8'h04, 1, 1, 2, 4'b0000)); // c34 granted
    tbl.push_back(mk( 1, 0, 4'b0000, 8'h00, 1, 1, 2, 4'b0000)); // c35 withdrawn
    tbl.push_back(mk( 5, 0, 4'b0000, 8'h00, 0, 1, 2, 4'b0000)); // c36-40 idle, tick ignored
    tbl.push_back(mk( 1, 0, 4'b0011, 8'h07, 0, 1, 2, 4'b0000)); // c41 req0+req1, search from 1
    tbl.push_back(mk( 8, 0, 4'b0011, 8'h07, 1, 1, 2, 4'b0000)); // c42-49
    tbl.push_back(mk( 1, 0, 4'b0011, 8'h07, 1, 1, 1, 4'b0010)); // c50 applied
    tbl.push_back(mk(19, 0, 4'b0001, 8'h07, 1, 1, 1, 4'b0000)); // c51-69 hold
    tbl.push_back(mk( 1, 0, 4'b0001, 8'h07, 0, 1, 1, 4'b0000)); // c70 idle
    tbl.push_back(mk( 9, 0, 4'b0001, 8'h07, 1, 0, 1, 4'b0000)); // c71-79 req0 waiting
    tbl.push_back(mk( 1, 0, 4'b0001, 8'h07, 1, 0, 3, 4'b0001)); // c80 duty 11
    tbl.push_back(mk( 3, 0, 4'b0000, 8'h00, 1, 0, 3, 4'b0000)); // c81-83 hold
    tbl.push_back(mk( 1, 1, 4'b0000, 8'h00, 1, 0, 3, 4'b0000)); // c84 reset mid-hold
    tbl.push_back(mk(10, 0, 4'b0000, 8'h00, 0, 0, 0, 4'b0000)); // c85-94 cleared, tick at 94
    tbl.push_back(mk( 1, 0, 4'b0101, 8'h21, 0, 0, 0, 4'b0000)); // c95 req0+req2
    tbl.push_back(mk( 9, 0, 4'b0101, 8'h21, 1, 0, 0, 4'b0000)); // c96-104
    tbl.push_back(mk( 1, 0, 4'b0101, 8'h21, 1, 0, 1, 4'b0001)); // c105 req0 applied
    tbl.push_back(mk(19, 0, 4'b0100, 8'h21, 1, 0, 1, 4'b0000)); // c106-124 hold
    tbl.push_back(mk( 1, 0, 4'b0100, 8'h21, 0, 0, 1, 4'b0000)); // c125 idle after hold
    tbl.push_back(mk( 9, 0, 4'b0100, 8'h21, 1, 2, 1, 4'b0000)); // c126-134 req2 waits next tick
    tbl.push_back(mk( 1, 0, 4'b0100, 8'h21, 1, 2, 2, 4'b0100)); // c135 req2 applied
    tbl.push_back(mk(19, 0, 4'b0000, 8'h00, 1, 2, 2, 4'b0000)); // c136-154 hold
    tbl.push_back(mk( 1, 0, 4'b0000, 8'h00, 0, 2, 2, 4'b0000)); // c155 idle
    tbl.push_back(mk( 1, 0, 4'b1001, 8'hC1, 0, 2, 2, 4'b0000)); // c156 req0+req3
    tbl.push_back(mk( 1, 0, 4'b1001, 8'hC1, 1, 3, 2, 4'b0000)); // c157 rr_ptr=3 picks 3
    tbl.push_back(mk( 1, 0, 4'b0000, 8'h00, 1, 3, 2, 4'b0000)); // c158 withdrawn
    tbl.push_back(mk( 2, 0, 4'b0000, 8'h00, 0, 3, 2, 4'b0000)); // c159-160 idle

    do_reset();
    fork
      run_table();
      run_boundary();
    join
    do_reset();
    run_fairness();
    do_reset();
    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sched.md
PWM_DUTY_SCHED -- requirements
Module: pwm_duty_sched

Interface
REQ-001 Parameter PERIOD, default 2_000_000, PWM period in clk cycles; SHALL match the period of the driven PWM generator.
REQ-002 Parameter HOLD_PERIODS, default 4, minimum PWM periods a granted duty is held, legal range 1..255.
REQ-003 Port clk  input  1  clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req  input  4  per-requester duty request; held high until ack.
REQ-006 Port req_duty  input  8  requester i duty code in bits [2i+1:2i].
REQ-007 Port ack  output  4  one-cycle pulse to requester i when its duty is applied.
REQ-008 Port duty_o  output  2  registered duty code to the PWM duty input.
REQ-009 Port grant_id  output  2  index of the current or last granted requester.
REQ-010 Port busy  output  1  high in WAIT_EDGE and HOLD.
REQ-011 Port period_tick  output  1  high for one cycle when the period counter equals PERIOD-1.

Function
REQ-012 The period counter SHALL run 0..PERIOD-1 and wrap to 0; it is aligned with a PWM generator released from the same rst.
REQ-013 The FSM SHALL have three states: IDLE, WAIT_EDGE and HOLD.
REQ-014 In IDLE with any req high, the FSM SHALL grant the first requester at or after rr_ptr (round-robin, wrapping 3->0). It latches grant_id and that requester's duty code, then goes to WAIT_EDGE on the next edge.
REQ-015 A grant made in IDLE SHALL NOT apply a duty in the same cycle, even if period_tick is high in that cycle.
REQ-016 In WAIT_EDGE, on the edge where period_tick=1, the FSM SHALL:
  - load duty_o with the latched code;
  - pulse ack[grant_id] for the following cycle only;
  - load hold_cnt with HOLD_PERIODS-1;
  - enter HOLD.
REQ-017 In WAIT_EDGE, if req[grant_id] falls before period_tick, the FSM SHALL return to IDLE. There is no ack, duty_o is unchanged and rr_ptr is unchanged.
REQ-018 In HOLD, hold_cnt SHALL decrement on each period_tick. On the period_tick with hold_cnt=0, the FSM SHALL set rr_ptr = grant_id+1 (mod 4) and enter IDLE.
REQ-019 Requests SHALL be ignored in HOLD; req changes in HOLD have no effect on duty_o.
REQ-020 duty_o SHALL retain its last applied value indefinitely; it changes only per REQ-016.
REQ-021 ack SHALL be one-hot or zero in every cycle.
REQ-022 With HOLD_PERIODS=1, HOLD SHALL last exactly one PWM period.

Reset
REQ-023 While rst=1, the following SHALL be cleared: period counter=0, state=IDLE, duty_o=2'b00, ack=0, grant_id=0, rr_ptr=0, hold_cnt=0, busy=0, period_tick=0.
REQ-024 Reset asserted mid-WAIT_EDGE or mid-HOLD SHALL abandon the grant with no ack issued afterwards.

Structure
REQ-025 The state encoding (IDLE, WAIT_EDGE, HOLD) and the default PERIOD constant SHALL live in the shared package pwm_pkg.
REQ-026 The period counter and tick SHALL be one sub-module, pwm_period_timer (parameter PERIOD; ports clk, rst, tick).
REQ-027 The FSM, round-robin pointer and hold counter SHALL live in pwm_duty_sched.

Verification (PERIOD=10, HOLD_PERIODS=2)
REQ-028 Single request: req[0]=1 with duty 2'b10 from cycle 2 -> busy=1 and grant_id=0 next cycle; duty_o=2'b10 and ack=4'b0001 after the cnt=9 edge; busy=0 after two further ticks.
REQ-029 Simultaneous requests: req[0] and req[2] together -> requester 0 served first. After its hold, requester 2 is granted and its duty is applied at the next tick, not the tick that ends the hold; rr_ptr ends at 3.
REQ-030 Fairness: all four req held high with distinct duties -> ack order 0,1,2,3,0 with no requester skipped.
REQ-031 Withdrawal: req[1] dropped during WAIT_EDGE -> no ack, duty_o unchanged, FSM back to IDLE, next grant still starts search at 1.
REQ-032 Reset mid-operation: rst pulsed during HOLD with duty_o=2'b11 -> next cycle duty_o=2'b00, busy=0, ack=0, counter=0.
REQ-033 Boundary: HOLD_PERIODS=1 and request raised in the cycle where period_tick=1 -> duty applied one full period later, then held exactly one period.
